// File: rtl/gcd_sched.sv
// Round-robin front end that shares one gcd engine between NREQ requesters.
// Zero-operand requests are answered locally; the engine only sees nonzero pairs.
module gcd_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   a_req,
    input  logic [NREQ*32-1:0]   b_req,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rsp_result,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy,
    output logic                 eng_start,
    output logic [31:0]          eng_a,
    output logic [31:0]          eng_b,
    input  logic [31:0]          eng_result,
    input  logic                 eng_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr, id, win, ptr_nxt;
    logic [31:0]    res, win_a, win_b;
    logic           found;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && req[(int'(ptr) + off) % NREQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + off) % NREQ);
            end
        end
    end

    assign win_a   = a_req[int'(win)*32 +: 32];
    assign win_b   = b_req[int'(win)*32 +: 32];
    assign ptr_nxt = (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;

    // Outputs decode from state and registered id/res only.
    assign busy       = (state != IDLE);
    assign eng_start  = (state == ISSUE);
    assign ack        = (state == RESP) ? (NREQ'(1) << id) : '0;
    assign rsp_result = (state == RESP) ? res : '0;
    assign rsp_id     = (state == RESP) ? id  : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            res   <= '0;
            eng_a <= '0;
            eng_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id <= win;
                        if (win_a == 32'd0 || win_b == 32'd0) begin
                            res   <= (win_a == 32'd0) ? win_b : win_a;
                            state <= RESP;
                        end else begin
                            eng_a <= win_a;
                            eng_b <= win_b;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (eng_done) begin
                        res   <= eng_result;
                        state <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= ptr_nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Bench for gcd_sched: behavioural engine, round-robin/GCD reference model and
// a scoreboard monitor that checks every response the scheduler presents.
module tb_gcd_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*32-1:0]  a_req = '0;
    logic [NREQ*32-1:0]  b_req = '0;
    logic [NREQ-1:0]     ack;
    logic [31:0]         rsp_result;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
    logic                eng_start;
    logic [31:0]         eng_a, eng_b;
    logic [31:0]         eng_result = '0;
    logic                eng_done = 1'b0;

    always #5 clk = ~clk;

    gcd_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .a_req(a_req), .b_req(b_req),
        .ack(ack), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_result(eng_result), .eng_done(eng_done)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      nm, act, act, exp, exp, $time);
    endtask

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 7) == 0) return 32'd0;
        return 32'($urandom_range(1, 97) * $urandom_range(1, 120));
    endfunction

    // Engine model: random latency, flags a second start before done.
    int          fixed_lat = -1;
    bit          stray = 1'b0;
    bit          e_busy = 1'b0;
    int          e_lat = 0;
    logic [31:0] e_a = '0, e_b = '0;
    int          n_start = 0, n_stray = 0;

    always begin
        @(posedge clk); #1;
        eng_done = 1'b0;
        if (!reset_n) e_busy = 1'b0;
        else begin
            if (e_busy) begin
                if (e_lat == 0) begin
                    eng_done = 1'b1; eng_result = gcd(e_a, e_b); e_busy = 1'b0;
                end else e_lat--;
            end else if (stray) begin
                eng_done = 1'b1; eng_result = 32'h1234; n_stray++;
            end
            if (eng_start) begin
                n_start++;
                chk("start_while_outstanding", 32'(e_busy), 32'd0);
                e_busy = 1'b1; e_a = eng_a; e_b = eng_b;
                e_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
            end
        end
    end

    // Reference model + scoreboard monitor, sampled on the falling edge.
    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] res; bit zero; } exp_t;
    exp_t sb[$];
    int   ack_log[$];
    int   phase = 0, m_ptr = 0, m_w;
    exp_t m_e;

    task automatic take_ack();
        exp_t e;
        if (sb.size() == 0) begin chk("scoreboard_empty_on_ack", 32'd1, 32'd0); phase = 0; return; end
        e = sb.pop_front();
        chk("ack_onehot", 32'(ack), 32'd1 << e.id);
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", rsp_result, e.res);
        chk("resp_busy", 32'(busy), 32'd1);
        ack_log.push_back(e.id);
        m_ptr = (e.id + 1) % NREQ;
        phase = 0;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            phase = 0; sb.delete(); m_ptr = 0;
        end else begin
            case (phase)
                0: begin
                    chk("idle_outputs", 32'({busy, eng_start, ack}), 32'd0);
                    if (|req) begin
                        m_w = -1;
                        for (int k = 0; k < NREQ; k++)
                            if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
                        m_e.id   = m_w;
                        m_e.a    = a_req[m_w*32 +: 32];
                        m_e.b    = b_req[m_w*32 +: 32];
                        m_e.res  = gcd(m_e.a, m_e.b);
                        m_e.zero = (m_e.a == 0) || (m_e.b == 0);
                        sb.push_back(m_e);
                        phase = 1;
                    end
                end
                1: begin
                    chk("granted_busy", 32'(busy), 32'd1);
                    if (sb[0].zero) take_ack();
                    else begin
                        chk("issue_start", 32'(eng_start), 32'd1);
                        chk("issue_ack", 32'(ack), 32'd0);
                        chk("eng_a", eng_a, sb[0].a);
                        chk("eng_b", eng_b, sb[0].b);
                        phase = 2;
                    end
                end
                2: begin
                    chk("wait_outputs", 32'({busy, eng_start, ack}), 32'({1'b1, 1'b0, 4'b0}));
                    if (eng_done) phase = 3;
                end
                default: take_ack();
            endcase
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        a_req[i*32 +: 32] = a; b_req[i*32 +: 32] = b; req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i);
        int c = 0;
        while (!ack[i] && c < 200) begin cyc(); c++; end
        chk($sformatf("ack%0d_arrives", i), 32'(ack[i]), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req = '0; cyc(2); reset_n = 1'b1; cyc(1);
    endtask

    int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int l0, s0, c;

    initial begin
        #1;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_outputs", 32'({busy, eng_start, rsp_id}), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_eng_ab", 32'(|{eng_a, eng_b}), 32'd0);
        chk("reset_ptr", 32'(dut.ptr), 32'd0);
        cyc(2); reset_n = 1'b1; cyc(1);

        // Single request
        s0 = n_start;
        set_req(0, 48, 18); wait_ack(0);
        chk("single_result", rsp_result, 32'd6);
        chk("single_id", 32'(rsp_id), 32'd0);
        req[0] = 1'b0; cyc(2);
        chk("single_one_start", 32'(n_start - s0), 32'd1);

        // Simultaneous requests 1 and 3
        do_reset(); l0 = ack_log.size();
        set_req(1, 21, 14); set_req(3, 100, 75);
        wait_ack(1); chk("simul_r1", rsp_result, 32'd7); req[1] = 1'b0;
        wait_ack(3); chk("simul_r3", rsp_result, 32'd25); req[3] = 1'b0;
        cyc(1);
        chk("simul_ptr_end", 32'(dut.ptr), 32'd0);
        chk("simul_count", 32'(ack_log.size() - l0), 32'd2);
        if (ack_log.size() >= l0 + 2) begin
            chk("simul_first", 32'(ack_log[l0]), 32'd1);
            chk("simul_second", 32'(ack_log[l0+1]), 32'd3);
        end

        // Fairness: all four hold req for 8 transactions
        do_reset(); l0 = ack_log.size();
        for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
        for (int t = 0; t < 8; t++) begin
            c = 0;
            while (ack == '0 && c < 200) begin cyc(); c++; end
            chk("fair_ack_arrives", 32'(ack != '0), 32'd1);
            for (int i = 0; i < NREQ; i++)
                if (ack[i]) begin
                    if (t < 7) set_req(i, rnd_op(), rnd_op());
                    else req = '0;
                end
            cyc(1);
        end
        req = '0; cyc(2);
        chk("fair_count", 32'(ack_log.size() - l0), 32'd8);
        if (ack_log.size() >= l0 + 8)
            for (int k = 0; k < 8; k++) chk($sformatf("fair_order%0d", k), 32'(ack_log[l0+k]), 32'(exp_ord[k]));

        // Zero bypass
        do_reset(); s0 = n_start;
        set_req(2, 0, 35); wait_ack(2); chk("zero_0_35", rsp_result, 32'd35);
        set_req(2, 0, 0); cyc(1); wait_ack(2); chk("zero_0_0", rsp_result, 32'd0);
        req[2] = 1'b0; cyc(2);
        chk("zero_no_start", 32'(n_start - s0), 32'd0);

        // Reset in the middle of WAIT
        do_reset(); fixed_lat = 30;
        set_req(0, 1071, 462);
        c = 0;
        while (!eng_start && c < 20) begin cyc(); c++; end
        chk("midrst_start_seen", 32'(eng_start), 32'd1);
        cyc(5); l0 = ack_log.size();
        reset_n = 1'b0; req[0] = 1'b0; #1;
        chk("midrst_ctrl_zero", 32'({ack, rsp_id, busy, eng_start}), 32'd0);
        chk("midrst_rsp_zero", rsp_result, 32'd0);
        chk("midrst_eng_ab_zero", 32'(|{eng_a, eng_b}), 32'd0);
        cyc(2); reset_n = 1'b1; fixed_lat = -1; cyc(3);
        chk("midrst_no_ack", 32'(ack_log.size() - l0), 32'd0);
        set_req(0, 1071, 462); wait_ack(0);
        chk("midrst_retry", rsp_result, 32'd21);
        req[0] = 1'b0; cyc(2);

        // Stray eng_done in IDLE
        l0 = ack_log.size();
        stray = 1'b1; cyc(2); stray = 1'b0; cyc(3);
        chk("stray_fired", 32'(n_stray > 0), 32'd1);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_state", 32'(dut.state), 32'd0);
        chk("stray_no_ack", 32'(ack_log.size() - l0), 32'd0);

        // Randomized traffic, then drain
        do_reset(); l0 = ack_log.size();
        for (int t = 0; t < 2000; t++) begin
            if (t >= 600 && req == '0) break;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if (t >= 600 || $urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else set_req(i, rnd_op(), rnd_op());
                end else if (!req[i] && t < 600 && $urandom_range(0, 3) == 0)
                    set_req(i, rnd_op(), rnd_op());
            end
            cyc(1);
        end
        cyc(3);
        chk("random_drained", 32'(req), 32'd0);
        chk("random_sb_empty", 32'(sb.size()), 32'd0);
        chk("random_enough_acks", 32'(ack_log.size() - l0 > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gcd_sched.md
# gcd_sched

Round-robin scheduler that shares one `gcd` engine between `NREQ` requesters. It accepts operand pairs from requesters, issues one computation at a time to the engine, and returns each result to the requester that asked for it. It resolves zero-operand requests locally, because the engine requires nonzero operands. It sits between the requesting client blocks and the single `gcd` instance, and drives that instance's `start`/`a_in`/`b_in` pins.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req`  input  NREQ  per-requester request level.
- `a_req`  input  NREQ*32  operand a; requester i occupies bits [32i+31:32i].
- `b_req`  input  NREQ*32  operand b; same packing as `a_req`.
- `ack`  output  NREQ  one-hot, one-cycle completion pulse.
- `rsp_result`  output  32  GCD result; valid only while `ack` is nonzero.
- `rsp_id`  output  IDW  index of the requester being acked.
- `busy`  output  1  high in every state except IDLE.
- `eng_start`  output  1  one-cycle start pulse to the engine.
- `eng_a`, `eng_b`  output  32 each  operands to the engine; registered and held stable.
- `eng_result`  input  32  engine result.
- `eng_done`  input  1  engine completion pulse.

## Operation
- Requester protocol:
  - Raise `req[i]` and hold `a_req`/`b_req` stable until `ack[i]`.
  - A `req[i]` still high in the cycle after `ack[i]` is treated as a new request.
- Arbitration:
  - Round-robin over the `req` vector, starting at pointer `ptr` (reset 0).
  - The lowest index >= `ptr`, wrapping modulo `NREQ`, wins.
  - At RESP, `ptr <= (id+1) mod NREQ`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if `|req`, latch the winner index `id`, `a_req[id]` and `b_req[id]`.
    - If either operand is zero, go to RESP with `res = (a==0) ? b : a`. gcd(0,0) = 0.
    - Otherwise go to ISSUE. `eng_a`/`eng_b` load the operands on this edge.
  - ISSUE: `eng_start = 1` for exactly this cycle. Go to WAIT.
  - WAIT: when `eng_done` is seen, capture `res <= eng_result` and go to RESP.
  - RESP: drive `ack[id] = 1`, `rsp_result = res`, `rsp_id = id`. Advance `ptr`. Go to IDLE.
- Deasserting `req[id]` during ISSUE or WAIT does not abort the transaction. The ack is still issued.
- Changes to other requesters' `req` during a transaction only affect the next arbitration.
- `eng_done` outside WAIT is ignored.
- At most one engine computation is outstanding at any time. `eng_start` is never asserted outside ISSUE.
- `ack` is zero-hot outside RESP and exactly one-hot in RESP.
- Reset values:
  - FSM to IDLE; `ptr`, `id`, `res` to 0.
  - `ack`, `rsp_result`, `rsp_id`, `busy`, `eng_start`, `eng_a`, `eng_b` all 0.
- Reset asserted mid-transaction discards the transaction and issues no ack. The engine shares `reset_n`, so it is also cleared.

## Timing
- Cycle 0 (IDLE, request sampled) is the grant edge.
- Nonzero path:
  - `eng_start` is high in cycle 1.
  - If `eng_done` arrives in cycle k, `ack` is high in cycle k+1.
  - The earliest next grant is cycle k+2.
- Zero bypass: `ack` is high in cycle 1. The next grant is cycle 2.
- All outputs are registered or decoded from state only. There are no combinational paths from `req`/`eng_done` to outputs.
- Back-to-back throughput: one grant every (engine latency + 3) cycles.

## Test plan
- Single request: `req[0]` with a=48, b=18.
  - Required: one `eng_start` pulse with `eng_a`=48, `eng_b`=18.
  - Required: `ack[0]` one cycle after `eng_done`, with `rsp_result`=6 and `rsp_id`=0.
- Simultaneous requests: `req[1]` (21,14) and `req[3]` (100,75) raised together after reset.
  - Required: requester 1 acked first with 7, then requester 3 with 25.
  - Required: `ptr` ends at 0.
- Fairness: all 4 requesters hold `req` high continuously for 8 transactions.
  - Required: ack order 0,1,2,3,0,1,2,3.
  - Required: never two `eng_start` pulses without an intervening `eng_done`.
- Zero bypass: `req[2]` with (0,35), then `req[2]` with (0,0).
  - Required: `ack[2]` in cycle 1 with 35, then with 0.
  - Required: `eng_start` never asserted.
- Reset mid-WAIT: assert `reset_n`=0 while waiting on (1071,462).
  - Required: all outputs go to 0 immediately and no ack is issued.
  - Required: after release, a new request (1071,462) returns 21.
- Stray `eng_done` pulse while in IDLE with no `req`.
  - Required: no `ack`, `busy` stays 0, and state is unchanged.
